// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: one load/store at a time over
// valid/ready, LATENCY wait states, byte-enabled stores and extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValidM,
    input  logic        ReqWriteM,
    input  logic [31:0] ReqAddrM,
    input  logic [31:0] ReqWDataM,
    input  logic [2:0]  ReqSizeM,
    output logic        ReqReadyM,
    output logic        StallM,
    output logic        RespValidM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state;
    state_t      nextState;
    logic [3:0]  waitCount;
    logic        reqWrite;
    logic [AW+1:0] reqAddr;
    logic [31:0] reqWData;
    logic [2:0]  reqSize;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic        accept;
    logic        misaligned;
    logic [AW-1:0] wordIdx;
    logic [3:0]  byteEn;
    logic [31:0] storeData;
    logic [31:0] memWord;
    logic [31:0] shifted;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic        unusedAddr;

    // Address bits above the array wrap away.
    assign unusedAddr = ^ReqAddrM[31:AW+2];

    assign accept     = (state == IDLE) && ReqValidM;
    assign misaligned = ((ReqSizeM[1:0] == 2'b01) && ReqAddrM[0]) ||
                        (ReqSizeM[1] && (ReqAddrM[1:0] != 2'b00));

    assign ReqReadyM  = (state == IDLE);
    assign StallM     = ~ReqReadyM;
    assign RespValidM = (state == RESP);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)        nextState = RESP;
                    else if (LATENCY == 0) nextState = ACCESS;
                    else                   nextState = WAIT;
                end
            end
            WAIT:    if (waitCount == 4'd0) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Lane steering: the store size ignores bit 2, so 1xx stores act as 0xx.
    always_comb begin
        wordIdx  = reqAddr[AW+1:2];
        memWord  = mem[wordIdx];
        shifted  = memWord >> {reqAddr[1:0], 3'b000};
        halfSel  = reqAddr[1] ? memWord[31:16] : memWord[15:0];
        byteEn   = 4'b1111;
        storeData = reqWData;
        case (reqSize[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << reqAddr[1:0];
                storeData = {4{reqWData[7:0]}};
            end
            2'b01: begin
                byteEn    = reqAddr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{reqWData[15:0]}};
            end
            default: ;
        endcase
        case (reqSize)
            3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  loadData = {24'd0, shifted[7:0]};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = memWord;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ACCESS && reqWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][b*8 +: 8] <= storeData[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            reqWrite  <= 1'b0;
            reqAddr   <= '0;
            reqWData  <= 32'd0;
            reqSize   <= 3'd0;
            ReadDataM <= 32'd0;
            MisalignM <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                reqWrite  <= ReqWriteM;
                reqAddr   <= ReqAddrM[AW+1:0];
                reqWData  <= ReqWDataM;
                reqSize   <= ReqSizeM;
                waitCount <= WAIT_INIT;
                MisalignM <= misaligned;
                if (misaligned) ReadDataM <= 32'd0;
            end
            if (state == WAIT && waitCount != 4'd0) waitCount <= waitCount - 4'd1;
            if (state == ACCESS) ReadDataM <= reqWrite ? 32'd0 : loadData;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 4, 0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid  [3];
    logic        reqWrite  [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWData  [3];
    logic [2:0]  reqSize   [3];
    logic        ready     [3];
    logic        stall     [3];
    logic        respValid [3];
    logic [31:0] readData  [3];
    logic        misalign  [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 4 : 0);

        dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
            .clk        (clk),
            .reset      (reset),
            .ReqValidM  (reqValid[g]),
            .ReqWriteM  (reqWrite[g]),
            .ReqAddrM   (reqAddr[g]),
            .ReqWDataM  (reqWData[g]),
            .ReqSizeM   (reqSize[g]),
            .ReqReadyM  (ready[g]),
            .StallM     (stall[g]),
            .RespValidM (respValid[g]),
            .ReadDataM  (readData[g]),
            .MisalignM  (misalign[g])
        );

        // Model: byte memory plus the interval index of the next response.
        logic [7:0]  mem [0:1023];
        int          cyc;
        int          readyFrom;
        int          respAt;
        logic [31:0] lastData;
        logic [31:0] pendResult;
        logic        expMis;
        logic        pendStore;
        int unsigned pendAddr;
        logic [31:0] pendData;
        int          pendBytes;

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
            cyc = 0; readyFrom = 0; respAt = -1; lastData = 0; pendResult = 0;
            expMis = 0; pendStore = 0; pendAddr = 0; pendData = 0; pendBytes = 0;
            forever begin
                @(posedge clk or posedge reset);
                cyc++;
                if (reset) begin
                    readyFrom = 0; respAt = -1; lastData = 0; expMis = 0; pendStore = 0;
                end else begin
                    if (cyc == respAt) begin
                        if (pendStore)
                            for (int b = 0; b < pendBytes; b++)
                                mem[(pendAddr + b) % 1024] = pendData[8*b +: 8];
                        lastData  = pendResult;
                        pendStore = 0;
                    end
                    if (reqValid[g] && (cyc - 1) >= readyFrom) begin
                        int unsigned a;
                        int          nb;
                        logic [31:0] v;
                        a  = reqAddr[g] % 1024;
                        nb = (reqSize[g][1:0] == 2'b00) ? 1 : ((reqSize[g][1:0] == 2'b01) ? 2 : 4);
                        if ((nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0)) begin
                            respAt   = cyc;
                            expMis   = 1;
                            lastData = 0;
                        end else begin
                            respAt = cyc + LAT + 1;
                            expMis = 0;
                            if (reqWrite[g]) begin
                                pendStore  = 1;
                                pendAddr   = a;
                                pendData   = reqWData[g];
                                pendBytes  = nb;
                                pendResult = 0;
                            end else begin
                                v = 0;
                                for (int b = 0; b < nb; b++) v[8*b +: 8] = mem[a + b];
                                if (nb == 1 && reqSize[g] == 3'b000) v = {{24{v[7]}}, v[7:0]};
                                if (nb == 2 && reqSize[g] == 3'b001) v = {{16{v[15]}}, v[15:0]};
                                pendResult = v;
                            end
                        end
                        readyFrom = respAt + 1;
                    end
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (!reset) begin
                    checkValue($sformatf("i%0d_ready", g), ready[g], cyc >= readyFrom);
                    checkValue($sformatf("i%0d_stall", g), stall[g], cyc < readyFrom);
                    checkValue($sformatf("i%0d_respValid", g), respValid[g], cyc == respAt);
                    checkValue($sformatf("i%0d_readData", g), readData[g], lastData);
                    if (cyc == respAt)
                        checkValue($sformatf("i%0d_misalign", g), misalign[g], expMis);
                end
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic w, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] size);
        int n;
        @(negedge clk);
        reqWrite[idx] = w;
        reqAddr[idx]  = addr;
        reqWData[idx] = wdata;
        reqSize[idx]  = size;
        reqValid[idx] = 1'b1;
        n = 0;
        while (!ready[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkValue("accept", ready[idx], 1'b1);
        @(posedge clk);
        @(negedge clk);
        reqValid[idx] = 1'b0;
    endtask

    task automatic checkOutput(input int idx, input logic [31:0] expData, input logic expMis,
                               input int expLat, input string name);
        int n;
        n = 0;
        while (!respValid[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkValue({name, "_resp"}, respValid[idx], 1'b1);
        checkValue({name, "_lat"}, n + 1, expLat);
        checkValue({name, "_data"}, readData[idx], expData);
        checkValue({name, "_mis"}, misalign[idx], expMis);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqValid[i] = 0; reqWrite[i] = 0; reqAddr[i] = 0; reqWData[i] = 0; reqSize[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkValue("rst_ready", ready[0], 1'b1);
        checkValue("rst_respValid", respValid[0], 1'b0);
        checkValue("rst_readData", readData[0], 32'h0);
        checkValue("rst_stall", stall[0], 1'b0);

        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 3'b010); checkOutput(0, 32'h0, 0, 3, "sw10");
        applyStimulus(0, 0, 32'h10, 32'h0, 3'b010);        checkOutput(0, 32'hDEADBEEF, 0, 3, "lw10");
        applyStimulus(0, 0, 32'h13, 32'h0, 3'b000);        checkOutput(0, 32'hFFFFFFDE, 0, 3, "lb13");
        applyStimulus(0, 0, 32'h13, 32'h0, 3'b100);        checkOutput(0, 32'h000000DE, 0, 3, "lbu13");
        applyStimulus(0, 0, 32'h12, 32'h0, 3'b001);        checkOutput(0, 32'hFFFFDEAD, 0, 3, "lh12");
        applyStimulus(0, 0, 32'h10, 32'h0, 3'b101);        checkOutput(0, 32'h0000BEEF, 0, 3, "lhu10");
        applyStimulus(0, 1, 32'h11, 32'h55, 3'b000);       checkOutput(0, 32'h0, 0, 3, "sb11");
        applyStimulus(0, 0, 32'h10, 32'h0, 3'b010);        checkOutput(0, 32'hDEAD55EF, 0, 3, "lwAfterSb");
        applyStimulus(0, 1, 32'h12, 32'h1234, 3'b001);     checkOutput(0, 32'h0, 0, 3, "sh12");
        applyStimulus(0, 0, 32'h10, 32'h0, 3'b010);        checkOutput(0, 32'h123455EF, 0, 3, "lwAfterSh");
        applyStimulus(0, 0, 32'h12, 32'h0, 3'b010);        checkOutput(0, 32'h0, 1, 1, "lwMis");
        applyStimulus(0, 1, 32'h13, 32'hFFFF, 3'b001);     checkOutput(0, 32'h0, 1, 1, "shMis");
        applyStimulus(0, 0, 32'h10, 32'h0, 3'b010);        checkOutput(0, 32'h123455EF, 0, 3, "lwAfterMis");
        applyStimulus(0, 1, 32'h400, 32'hA5A5A5A5, 3'b010); checkOutput(0, 32'h0, 0, 3, "sw400");
        applyStimulus(0, 0, 32'h0, 32'h0, 3'b010);        checkOutput(0, 32'hA5A5A5A5, 0, 3, "lwWrap");

        applyStimulus(2, 1, 32'h8, 32'hCAFEF00D, 3'b010);  checkOutput(2, 32'h0, 0, 2, "lat0Sw");
        applyStimulus(2, 0, 32'h8, 32'h0, 3'b010);         checkOutput(2, 32'hCAFEF00D, 0, 2, "lat0Lw");

        applyStimulus(1, 1, 32'h20, 32'h11223344, 3'b010); checkOutput(1, 32'h0, 0, 6, "lat4Sw");
        applyStimulus(1, 1, 32'h20, 32'h99999999, 3'b010);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (respValid[1]) cnt++;
        end
        checkValue("noRespAfterReset", cnt, 0);
        applyStimulus(1, 0, 32'h20, 32'h0, 3'b010);        checkOutput(1, 32'h11223344, 0, 6, "lwAfterReset");
        applyStimulus(0, 0, 32'h0, 32'h0, 3'b010);         checkOutput(0, 32'hA5A5A5A5, 0, 3, "memKept");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's memory stage; it is the memory-side end of the load/store interface the pipeline drives.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a parameterised number of wait states, then commits stores with byte enables, or returns sign/zero-extended load data with a one-cycle response pulse.
- Flags misaligned accesses instead of performing them. The hazard unit uses StallM (= ~ReqReadyM) to freeze the pipeline.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two, at least 2.
- LATENCY, 1, wait-state cycles between request acceptance and the access; 0 to 15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ReqValidM  input  1  request present.
- ReqWriteM  input  1  1 = store, 0 = load.
- ReqAddrM  input  32  byte address.
- ReqWDataM  input  32  store data, right-aligned.
- ReqSizeM  input  3  funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (the unsigned codes apply to loads only).
- ReqReadyM  output  1  responder can accept a request.
- StallM  output  1  equals ~ReqReadyM.
- RespValidM  output  1  one-cycle response/ack pulse.
- ReadDataM  output  32  extended load data; valid while RespValidM=1.
- MisalignM  output  1  response carries a misalignment error; valid while RespValidM=1.

Behaviour:
- Reset values (asynchronous): state IDLE; ReqReadyM=1, StallM=0, RespValidM=0, ReadDataM=0, MisalignM=0; wait counter and request latches 0.
- Memory array contents are not reset. Reset mid-transaction returns the block to IDLE; an uncommitted store is dropped.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - ReqReadyM=1.
  - A request is accepted when ReqValidM=1 and ReqReadyM=1. On acceptance, latch write, addr, wdata and size.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with MisalignM=1, ReadDataM=0, no memory write.
  - Aligned request: if LATENCY=0 go to ACCESS; otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter; go to ACCESS when it reaches 0. WAIT lasts exactly LATENCY cycles.
- ACCESS (one cycle):
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Store byte enables: byte → lane addr[1:0] gets wdata[7:0]; half → lanes {addr[1],0}, {addr[1],1} get wdata[15:0]; word → all lanes. Other lanes are unchanged.
  - Store size codes 1xx are treated as their 0xx equivalents.
  - Load: select the byte or half at the same lanes. Codes 000/001 sign-extend, 100/101 zero-extend, 010 returns the full word. Codes 011, 110 and 111 behave as word.
  - Register the result into ReadDataM; for stores ReadDataM=0. The store commits on the ACCESS→RESP edge. Go to RESP.
- RESP (one cycle):
  - RespValidM=1 and MisalignM is valid. ReadDataM holds its value until the next response.
  - Next state is IDLE. A new request cannot be accepted in RESP.
- ReqReadyM=1 only in IDLE.
- Latency: a request accepted at edge T produces RespValidM=1 during cycle T+LATENCY+2 (aligned) or T+1 (misaligned). Throughput is one request per LATENCY+3 cycles.
- A load issued after a store to the same word observes the stored data.
- Request inputs are ignored outside IDLE.

Test Plan:
- Reset with all request inputs idle, LATENCY=1 → after reset deasserts: ReqReadyM=1, RespValidM=0, ReadDataM=0, StallM=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → the store's RespValidM pulses 3 cycles after acceptance with MisalignM=0; the load returns 0xDEADBEEF; StallM is high for exactly 3 cycles per request.
- With word 0x10=0xDEADBEEF: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF (other lanes preserved). SH 0x12 data 0x1234, then LW → 0x123455EF.
- LW 0x12 and SH 0x13 → RespValidM one cycle after acceptance with MisalignM=1; memory unchanged; a following LW 0x10 returns the prior value.
- Address wrap, DEPTH_WORDS=256: SW 0x400 data 0xA5A5A5A5, then LW 0x0 → 0xA5A5A5A5.
- Reset mid-WAIT of SW 0x20 with LATENCY=4 → block returns to IDLE, no RespValidM pulse; a subsequent LW 0x20 returns the old contents.
- LATENCY=0: response arrives 2 cycles after acceptance.
